// File: rtl/pwm_decoder_pkg.sv
// Shared PWM drive-path definitions: direction codes and default timing,
// common to the motor PWM driver and this receive-side decoder.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    DIR_BRAKE = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_REV   = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEAS = 2'b01,
    ST_FLT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    REQ_DEC = 2'b00,
    REQ_TMO = 2'b01,
    REQ_FLT = 2'b10
  } req_kind_t;

  localparam int DEF_SD      = 5;
  localparam int DEF_PERIOD  = 51;
  localparam int DEF_TIMEOUT = 102;

  // Level k is reached when (width-1) >= k*SD - SD/2, i.e. nearest-step rounding.
  function automatic int level_thr(input int k, input int sd);
    return k * sd - sd / 32'sd2;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus history flop for one PWM line, giving the
// synchronized level and single-clock rise/fall strobes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic p_r;
  logic seen_r;
  logic armed_r;

  // Synchronizer, history flop and arm flag (a line high across reset must go low first)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      p_r     <= 1'b0;
      seen_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      s1_r    <= line;
      s2_r    <= s1_r;
      p_r     <= s2_r;
      seen_r  <= 1'b1;
      armed_r <= armed_r | (seen_r & ~s1_r);
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~p_r & armed_r;
  assign fall  = ~s2_r & p_r;

endmodule

// File: rtl/pwm_decoder.sv
// Receive-side PWM decoder: measures pulse high time on the two direction lines
// and recovers direction/speed, flagging line faults and timing out to brake.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int SD      = DEF_SD,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in1,
  input  logic          pwm_in2,
  output logic [1:0]    choose,
  output logic [1:0]    speed,
  output logic          valid,
  output logic          fault,
  output logic [CW-1:0] width
);

  localparam logic [CW-1:0] W_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] W_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] W_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] PERIOD_W = CW'(PERIOD);
  localparam logic [CW-1:0] TMO_W    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] THR1     = CW'(level_thr(32'sd1, SD));
  localparam logic [CW-1:0] THR2     = CW'(level_thr(32'sd2, SD));
  localparam logic [CW-1:0] THR3     = CW'(level_thr(32'sd3, SD));

  logic lvl1_s, rise1_s, fall1_s;
  logic lvl2_s, rise2_s, fall2_s;

  pwm_edge_sync u_sync1 (.clk(clk), .rst(rst), .line(pwm_in1),
                         .level(lvl1_s), .rise(rise1_s), .fall(fall1_s));
  pwm_edge_sync u_sync2 (.clk(clk), .rst(rst), .line(pwm_in2),
                         .level(lvl2_s), .rise(rise2_s), .fall(fall2_s));

  state_t        state_r, state_s;
  dir_t          dir_r, dir_s;
  logic [CW-1:0] wcnt_r, wcnt_s;
  logic [CW-1:0] gap_r, gap_s;
  logic          req_vld_r, req_vld_s;
  req_kind_t     req_kind_r, req_kind_s;
  dir_t          req_dir_r;
  logic [CW-1:0] req_w_r;
  logic          lat_lvl_s, lat_fall_s, oth_lvl_s;
  logic [CW-1:0] d_s;
  logic [1:0]    lvl_s;
  logic [1:0]    choose_r, speed_r;
  logic          valid_r, fault_r;
  logic [CW-1:0] width_r;

  assign lat_lvl_s  = (dir_r == DIR_FWD) ? lvl1_s  : lvl2_s;
  assign lat_fall_s = (dir_r == DIR_FWD) ? fall1_s : fall2_s;
  assign oth_lvl_s  = (dir_r == DIR_FWD) ? lvl2_s  : lvl1_s;

  // FSM state, latched line, counters and the one-deep update request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      dir_r      <= DIR_BRAKE;
      wcnt_r     <= W_ZERO;
      gap_r      <= W_ZERO;
      req_vld_r  <= 1'b0;
      req_kind_r <= REQ_DEC;
      req_dir_r  <= DIR_BRAKE;
      req_w_r    <= W_ZERO;
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      wcnt_r     <= wcnt_s;
      gap_r      <= gap_s;
      req_vld_r  <= req_vld_s;
      req_kind_r <= req_kind_s;
      req_dir_r  <= dir_r;
      req_w_r    <= wcnt_r;
    end
  end

  // Next-state logic; update requests go through one register so valid lands at N+3
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    wcnt_s     = wcnt_r;
    gap_s      = gap_r;
    req_vld_s  = 1'b0;
    req_kind_s = REQ_DEC;
    case (state_r)
      ST_IDLE: begin
        if (lvl1_s && lvl2_s) begin
          // Hold off one clock if a strobe is already in flight, keeping valid isolated
          if (!req_vld_r) begin
            state_s    = ST_FLT;
            req_vld_s  = 1'b1;
            req_kind_s = REQ_FLT;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (rise1_s) begin
          state_s = ST_MEAS;
          dir_s   = DIR_FWD;
          wcnt_s  = W_ONE;
        end else if (rise2_s) begin
          state_s = ST_MEAS;
          dir_s   = DIR_REV;
          wcnt_s  = W_ONE;
        end else if (gap_r < TMO_W) begin
          gap_s = gap_r + W_ONE;
          if (gap_r == TMO_M1) begin
            req_vld_s  = 1'b1;
            req_kind_s = REQ_TMO;
          end else begin
            req_vld_s = 1'b0;
          end
        end else begin
          gap_s = gap_r;
        end
      end
      ST_MEAS: begin
        if (oth_lvl_s) begin
          state_s    = ST_FLT;
          req_vld_s  = 1'b1;
          req_kind_s = REQ_FLT;
        end else if (lat_fall_s) begin
          state_s    = ST_IDLE;
          gap_s      = W_ZERO;
          req_vld_s  = 1'b1;
          req_kind_s = REQ_DEC;
        end else if (wcnt_r > PERIOD_W) begin
          state_s    = ST_FLT;
          req_vld_s  = 1'b1;
          req_kind_s = REQ_FLT;
        end else if (lat_lvl_s && (wcnt_r != W_MAX)) begin
          wcnt_s = wcnt_r + W_ONE;
        end else begin
          wcnt_s = wcnt_r;
        end
      end
      ST_FLT: begin
        gap_s = W_ZERO;
        if (!lvl1_s && !lvl2_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Speed level from the measured width by threshold compares
  always_comb begin
    d_s = req_w_r - W_ONE;
    if (d_s >= THR3) begin
      lvl_s = 2'd3;
    end else if (d_s >= THR2) begin
      lvl_s = 2'd2;
    end else if (d_s >= THR1) begin
      lvl_s = 2'd1;
    end else begin
      lvl_s = 2'd0;
    end
  end

  // Output registers, updated only when a request is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      choose_r <= 2'b00;
      speed_r  <= 2'b00;
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
      width_r  <= W_ZERO;
    end else begin
      valid_r <= req_vld_r;
      if (req_vld_r) begin
        case (req_kind_r)
          REQ_DEC: begin
            choose_r <= req_dir_r;
            speed_r  <= lvl_s;
            width_r  <= req_w_r;
            fault_r  <= 1'b0;
          end
          REQ_TMO: begin
            choose_r <= DIR_BRAKE;
            speed_r  <= 2'b00;
          end
          REQ_FLT: begin
            choose_r <= DIR_BRAKE;
            speed_r  <= 2'b00;
            fault_r  <= 1'b1;
          end
          default: begin
            choose_r <= DIR_BRAKE;
            speed_r  <= 2'b00;
          end
        endcase
      end
    end
  end

  assign choose = choose_r;
  assign speed  = speed_r;
  assign valid  = valid_r;
  assign fault  = fault_r;
  assign width  = width_r;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: expected decodes are queued as pulses are
// driven and compared whenever the decoder strobes valid.
module tb_pwm_decoder;
  import pwm_decoder_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in1;
  logic          pwm_in2;
  logic [1:0]    choose;
  logic [1:0]    speed;
  logic          valid;
  logic          fault;
  logic [CW-1:0] width;

  pwm_decoder #(.SD(5), .PERIOD(51), .TIMEOUT(102), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pwm_in1(pwm_in1), .pwm_in2(pwm_in2),
    .choose(choose), .speed(speed), .valid(valid), .fault(fault), .width(width)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    choose;
    logic [1:0]    speed;
    logic          fault;
    logic [CW-1:0] width;
    int            gap;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [CW-1:0] model_width = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] c, input logic [1:0] s, input logic f,
                          input logic [CW-1:0] w, input int gap);
    exp_t e;
    e.choose = c; e.speed = s; e.fault = f; e.width = w; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic pulse(input int line, input int hi, input int lo);
    @(negedge clk);
    if (line == 1) pwm_in1 = 1'b1; else pwm_in2 = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in1 = 1'b0;
    pwm_in2 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic decode_pulse(input int line, input int hi, input int lo, input logic [1:0] spd);
    push_exp((line == 1) ? 2'b01 : 2'b10, spd, 1'b0, CW'(hi), -1);
    model_width = CW'(hi);
    pulse(line, hi, lo);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every valid strobe
  initial begin
    exp_t e;
    logic prev_valid;
    int last_strobe;
    prev_valid = 1'b0;
    last_strobe = 0;
    forever begin
      @(negedge clk);
      if (valid) begin
        check_eq("no_back2back", prev_valid, 0);
        check_eq("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("choose", choose, e.choose);
          check_eq("speed", speed, e.speed);
          check_eq("fault", fault, e.fault);
          check_eq("width", width, e.width);
          if (e.gap >= 0) check_eq("strobe_gap", cyc - last_strobe, e.gap);
        end
        last_strobe = cyc;
      end
      prev_valid = valid;
    end
  end

  int sweep_hi[5]  = '{1, 6, 11, 16, 21};
  int sweep_spd[5] = '{0, 1, 2, 3, 3};

  initial begin
    rst = 1'b1;
    pwm_in1 = 1'b0;
    pwm_in2 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_choose", choose, 0);
    check_eq("rst_speed", speed, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_width", width, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Forward speed 2, three periods
    for (int i = 0; i < 3; i++) decode_pulse(1, 11, 40, 2'd2);

    // Reverse sweep
    for (int i = 0; i < 5; i++) decode_pulse(2, sweep_hi[i], 51 - sweep_hi[i], 2'(sweep_spd[i]));

    // Rounding boundary
    decode_pulse(1, 3, 30, 2'd0);
    decode_pulse(1, 4, 30, 2'd1);

    // Overlap fault, then clean pulse clears it
    push_exp(2'b00, 2'b00, 1'b1, model_width, -1);
    @(negedge clk);
    pwm_in1 = 1'b1;
    repeat (4) @(negedge clk);
    pwm_in2 = 1'b1;
    repeat (6) @(negedge clk);
    pwm_in1 = 1'b0;
    pwm_in2 = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("fault_held", fault, 1);
    decode_pulse(1, 6, 30, 2'd1);
    check_eq("fault_cleared", fault, 0);

    // Stuck high beyond PERIOD: fault, no decode on the fall
    push_exp(2'b00, 2'b00, 1'b1, model_width, -1);
    @(negedge clk);
    pwm_in1 = 1'b1;
    repeat (60) @(negedge clk);
    pwm_in1 = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("stuck_fault", fault, 1);

    // Timeout exactly 102 clocks after the decode strobe, then silence
    push_exp(2'b01, 2'd2, 1'b0, 16'd11, -1);
    push_exp(2'b00, 2'b00, 1'b0, 16'd11, 102);
    pulse(1, 11, 10);
    repeat (250) @(negedge clk);
    check_eq("tmo_choose", choose, 0);

    // Reset mid-pulse; the still-high line is ignored afterwards
    decode_pulse(1, 11, 20, 2'd2);
    @(negedge clk);
    pwm_in2 = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_choose", choose, 0);
    check_eq("mid_rst_speed", speed, 0);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_fault", fault, 0);
    check_eq("mid_rst_width", width, 0);
    rst = 1'b0;
    push_exp(2'b00, 2'b00, 1'b0, 16'd0, -1);
    repeat (10) @(negedge clk);
    pwm_in2 = 1'b0;
    repeat (150) @(negedge clk);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
